// File: rtl/ep_writeback.sv
// ep_writeback: even-pipe result writeback slot pipeline; s[STAGES] drives the register-file write port.
// Define EP_WRITEBACK_FORWARD_EN to build the forwarding lookup; otherwise fw_hit/fw_value are tied to 0.
module ep_writeback #(
    parameter int STAGES = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         result_valid,
    input  logic [0:127] result_value,
    input  logic [0:6]   result_rt_address,
    input  logic [0:3]   result_latency,
    input  logic         flush,
    input  logic [0:6]   fw_address,
    output logic         wrt_en_ep,
    output logic [0:6]   rt_address_ep,
    output logic [0:127] rt_value_ep,
    output logic         fw_hit,
    output logic [0:127] fw_value,
    output logic         err_pulse
);

    logic         r_valid [1:STAGES];
    logic [0:6]   r_addr  [1:STAGES];
    logic [0:127] r_value [1:STAGES];
    logic         r_err;

    logic         w_nValid [1:STAGES];
    logic [0:6]   w_nAddr  [1:STAGES];
    logic [0:127] w_nValue [1:STAGES];
    int           w_lat;
    logic         w_latOk;
    logic         w_collide;
    logic         w_accept;
    logic         w_reject;

    // The entry that would shift into the target slot is s[STAGES-L]; L=STAGES has no such slot.
    always_comb begin
        w_lat     = {28'd0, result_latency};
        w_latOk   = (w_lat >= 1) && (w_lat <= STAGES);
        w_collide = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (k == STAGES - w_lat) begin
                w_collide = r_valid[k];
            end
        end
        w_accept = result_valid && !flush && w_latOk && !w_collide;
        w_reject = result_valid && !flush && (!w_latOk || w_collide);
    end

    always_comb begin
        w_nValid[1] = 1'b0;
        w_nAddr[1]  = '0;
        w_nValue[1] = '0;
        for (int k = 2; k <= STAGES; k++) begin
            w_nValid[k] = r_valid[k-1];
            w_nAddr[k]  = r_addr[k-1];
            w_nValue[k] = r_value[k-1];
        end
        for (int k = 1; k <= STAGES; k++) begin
            if (w_accept && (k == STAGES - w_lat + 1)) begin
                w_nValid[k] = 1'b1;
                w_nAddr[k]  = result_rt_address;
                w_nValue[k] = result_value;
            end
        end
        if (flush) begin
            for (int k = 1; k <= STAGES; k++) begin
                w_nValid[k] = 1'b0;
            end
        end
    end

    // The last slot only loads data with a valid entry so the write port holds its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_addr[k]  <= '0;
                r_value[k] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= w_nValid[k];
                r_addr[k]  <= w_nAddr[k];
                r_value[k] <= w_nValue[k];
            end
            r_valid[STAGES] <= w_nValid[STAGES];
            if (w_nValid[STAGES]) begin
                r_addr[STAGES]  <= w_nAddr[STAGES];
                r_value[STAGES] <= w_nValue[STAGES];
            end
            r_err <= w_reject;
        end
    end

    assign wrt_en_ep     = r_valid[STAGES];
    assign rt_address_ep = r_addr[STAGES];
    assign rt_value_ep   = r_value[STAGES];
    assign err_pulse     = r_err;

`ifdef EP_WRITEBACK_FORWARD_EN
    // Later slots hold the older-issued but sooner-written result; the highest index wins.
    always_comb begin
        fw_hit   = 1'b0;
        fw_value = '0;
        for (int k = 1; k <= STAGES; k++) begin
            if (r_valid[k] && (r_addr[k] == fw_address)) begin
                fw_hit   = 1'b1;
                fw_value = r_value[k];
            end
        end
    end
`else
    logic [0:6] w_unusedFwAddress;
    assign w_unusedFwAddress = fw_address;
    assign fw_hit            = 1'b0;
    assign fw_value          = '0;
`endif

endmodule

// File: tb/tb_ep_writeback.sv
// tb_ep_writeback: table-driven directed vectors for ep_writeback (STAGES=7), one record per clock cycle.
// Forwarding expectations apply when EP_WRITEBACK_FORWARD_EN is defined; otherwise fw outputs must stay 0.
module tb_ep_writeback;

`ifdef EP_WRITEBACK_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clock;
    logic         reset;
    logic         result_valid;
    logic [0:127] result_value;
    logic [0:6]   result_rt_address;
    logic [0:3]   result_latency;
    logic         flush;
    logic [0:6]   fw_address;
    logic         wrt_en_ep;
    logic [0:6]   rt_address_ep;
    logic [0:127] rt_value_ep;
    logic         fw_hit;
    logic [0:127] fw_value;
    logic         err_pulse;

    typedef struct {
        logic         valid;
        logic [6:0]   rt;
        logic [3:0]   lat;
        logic [127:0] value;
        logic         flush;
        logic         rst;
        logic [6:0]   fwAddr;
        logic         eWen;
        logic [6:0]   eAddr;
        logic [127:0] eVal;
        logic         eErr;
        logic         eHit;
        logic [127:0] eFw;
    } vec_t;

    vec_t vecs[$];
    int   nApplied;
    int   nMiscompares;

    ep_writeback #(.STAGES(7)) dut (
        .clock             (clock),
        .reset             (reset),
        .result_valid      (result_valid),
        .result_value      (result_value),
        .result_rt_address (result_rt_address),
        .result_latency    (result_latency),
        .flush             (flush),
        .fw_address        (fw_address),
        .wrt_en_ep         (wrt_en_ep),
        .rt_address_ep     (rt_address_ep),
        .rt_value_ep       (rt_value_ep),
        .fw_hit            (fw_hit),
        .fw_value          (fw_value),
        .err_pulse         (err_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mkVec(input logic v, input logic [6:0] rt, input logic [3:0] lat,
                                   input logic [127:0] val, input logic fl, input logic rs,
                                   input logic [6:0] fa, input logic eWen, input logic [6:0] eAddr,
                                   input logic [127:0] eVal, input logic eErr, input logic eHit,
                                   input logic [127:0] eFw);
        vec_t r;
        r.valid = v;   r.rt = rt;       r.lat = lat;     r.value = val;
        r.flush = fl;  r.rst = rs;      r.fwAddr = fa;
        r.eWen = eWen; r.eAddr = eAddr; r.eVal = eVal;   r.eErr = eErr;
        r.eHit = eHit; r.eFw = eFw;
        return r;
    endfunction

    task automatic addVec(input logic v, input logic [6:0] rt, input logic [3:0] lat,
                          input logic [127:0] val, input logic fl, input logic rs,
                          input logic [6:0] fa, input logic eWen, input logic [6:0] eAddr,
                          input logic [127:0] eVal, input logic eErr, input logic eHit,
                          input logic [127:0] eFw);
        vecs.push_back(mkVec(v, rt, lat, val, fl, rs, fa, eWen, eAddr, eVal, eErr, eHit, eFw));
    endtask

    task automatic addIdle(input int n, input logic [6:0] fa, input logic [6:0] eAddr,
                           input logic [127:0] eVal, input logic eHit, input logic [127:0] eFw);
        for (int i = 0; i < n; i++) begin
            addVec(0, 0, 0, 0, 0, 0, fa, 0, eAddr, eVal, 0, eHit, eFw);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset             = v.rst;
        result_valid      = v.valid;
        result_rt_address = v.rt;
        result_latency    = v.lat;
        result_value      = v.value;
        flush             = v.flush;
        fw_address        = v.fwAddr;
    endtask

    task automatic check1(input string tag, input string name,
                          input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        check1(tag, "wrt_en_ep",     {127'd0, wrt_en_ep}, {127'd0, v.eWen});
        check1(tag, "rt_address_ep", {121'd0, rt_address_ep}, {121'd0, v.eAddr});
        check1(tag, "rt_value_ep",   rt_value_ep, v.eVal);
        check1(tag, "err_pulse",     {127'd0, err_pulse}, {127'd0, v.eErr});
        check1(tag, "fw_hit",        {127'd0, fw_hit}, {127'd0, FWD ? v.eHit : 1'b0});
        check1(tag, "fw_value",      fw_value, FWD ? v.eFw : 128'd0);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later, mid-cycle.
    task automatic runVec(input vec_t v, input string tag);
        @(posedge clock);
        #1;
        applyStimulus(v);
        #1;
        checkOutput(v, tag);
        nApplied++;
    endtask

    initial begin
        nApplied     = 0;
        nMiscompares = 0;
        applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);

        // valid, rt, L, value, flush, reset, fw | wen, addr, value, err | hit, fwValue
        addVec(1, 5, 2, 30, 0, 0, 5,       0, 0, 0, 0,         0, 0);
        addVec(0, 0, 0, 0, 0, 0, 5,        0, 0, 0, 0,         1, 30);
        addVec(0, 0, 0, 0, 0, 0, 5,        1, 5, 30, 0,        1, 30);
        addVec(0, 0, 0, 0, 0, 0, 5,        0, 5, 30, 0,        0, 0);

        addVec(1, 3, 4, 'h33, 0, 0, 3,     0, 5, 30, 0,        0, 0);
        addVec(1, 4, 3, 'h44, 0, 0, 3,     0, 5, 30, 0,        1, 'h33);
        addVec(0, 0, 0, 0, 0, 0, 4,        0, 5, 30, 1,        0, 0);
        addVec(0, 0, 0, 0, 0, 0, 4,        0, 5, 30, 0,        0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        1, 3, 'h33, 0,      1, 'h33);
        addVec(0, 0, 0, 0, 0, 0, 3,        0, 3, 'h33, 0,      0, 0);

        addVec(1, 10, 5, 'hA0, 0, 0, 10,   0, 3, 'h33, 0,      0, 0);
        addVec(1, 11, 5, 'hA1, 0, 0, 10,   0, 3, 'h33, 0,      1, 'hA0);
        addVec(1, 12, 5, 'hA2, 1, 0, 10,   0, 3, 'h33, 0,      1, 'hA0);
        addIdle(7, 10, 3, 'h33, 0, 0);

        addVec(1, 1, 1, 'h11, 0, 0, 1,     0, 3, 'h33, 0,      0, 0);
        addVec(1, 8, 6, 'h88, 0, 0, 1,     1, 1, 'h11, 0,      1, 'h11);
        addVec(1, 9, 7, 'h99, 0, 0, 8,     0, 1, 'h11, 0,      1, 'h88);
        addIdle(4, 9, 1, 'h11, 1, 'h99);
        addVec(0, 0, 0, 0, 0, 0, 8,        1, 8, 'h88, 0,      1, 'h88);
        addVec(0, 0, 0, 0, 0, 0, 9,        0, 8, 'h88, 0,      1, 'h99);
        addVec(0, 0, 0, 0, 0, 0, 9,        1, 9, 'h99, 0,      1, 'h99);
        addVec(0, 0, 0, 0, 0, 0, 9,        0, 9, 'h99, 0,      0, 0);

        addVec(1, 1, 2, 'h21, 0, 0, 1,     0, 9, 'h99, 0,      0, 0);
        addVec(1, 2, 1, 'h22, 0, 0, 2,     0, 9, 'h99, 0,      0, 0);
        addVec(0, 0, 0, 0, 0, 0, 2,        1, 1, 'h21, 1,      0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1,        0, 1, 'h21, 0,      0, 0);

        addVec(1, 20, 0, 'h50, 0, 0, 20,   0, 1, 'h21, 0,      0, 0);
        addVec(1, 21, 9, 'h51, 0, 0, 21,   0, 1, 'h21, 1,      0, 0);
        addVec(1, 22, 15, 'h52, 0, 0, 21,  0, 1, 'h21, 1,      0, 0);
        addVec(0, 0, 0, 0, 0, 0, 21,       0, 1, 'h21, 1,      0, 0);
        addIdle(7, 21, 1, 'h21, 0, 0);

        addVec(1, 6, 4, 'h66, 0, 0, 6,     0, 1, 'h21, 0,      0, 0);
        addVec(1, 7, 5, 'h77, 0, 0, 6,     0, 1, 'h21, 0,      1, 'h66);
        addVec(1, 13, 0, 'h13, 0, 1, 6,    0, 1, 'h21, 0,      1, 'h66);
        addIdle(7, 6, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Same register in flight twice: the sooner-written copy must be forwarded while present.
        runVec(mkVec(1, 7, 7, 10, 0, 0, 7,  0, 0, 0, 0,  0, 0),  "fwd1");
        runVec(mkVec(1, 7, 2, 20, 0, 0, 7,  0, 0, 0, 0,  1, 10), "fwd2");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   0, 0, 0, 0,  1, 20), "fwd3");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   1, 7, 20, 0, 1, 20), "fwd4");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   0, 7, 20, 0, 1, 10), "fwd5");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   0, 7, 20, 0, 1, 10), "fwd6");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   0, 7, 20, 0, 1, 10), "fwd7");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   1, 7, 10, 0, 1, 10), "fwd8");
        runVec(mkVec(0, 0, 0, 0, 0, 0, 7,   0, 7, 10, 0, 0, 0),  "fwd9");

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
